// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and retry counter width.
package pll_seq_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input; resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the board PLL from reset to a qualified lock, then releases the core reset.
// Optional retry limit with fail state: define PLL_RETRY_LIMIT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 30000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic               osc_300,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_rst_n,
  output logic [2:0]         seq_state,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fail
);

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_T) + 1;

  logic               w_locked_s;
  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [CNT_W-1:0]   r_count;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] r_consec;
  logic               r_pll_rst;
  logic               r_core_rst_n;
  logic               r_fail;
  logic               w_retry_evt;
  logic               w_limit_hit;
  logic               w_pll_rst_nxt;
  logic               w_core_rst_n_nxt;
  logic               w_fail_nxt;

  sync_2ff u_lock_sync (
    .i_clk   (osc_300),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Without the limit this is constant 0, so S_FAIL can never be chosen.
  assign w_limit_hit = LIMIT_EN && (r_consec == RETRY_W'(MAX_RETRIES - 1));

  always_ff @(posedge osc_300 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_PLL_RST;
      r_count      <= '0;
      r_retry      <= '0;
      r_consec     <= '0;
      r_pll_rst    <= 1'b1;
      r_core_rst_n <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_count      <= (w_next != r_state) ? '0 : r_count + 1'b1;
      r_pll_rst    <= w_pll_rst_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_fail       <= w_fail_nxt;
      if (w_retry_evt && (w_next == S_PLL_RST) && (r_retry != '1))
        r_retry <= r_retry + 1'b1;
      if (w_next == S_RUN)
        r_consec <= '0;
      else if (w_retry_evt && (r_consec != '1))
        r_consec <= r_consec + 1'b1;
    end
  end

  // Lock beats timeout in S_WAIT_LOCK; a drop beats terminal count in S_STABLE.
  always_comb begin
    w_next      = r_state;
    w_retry_evt = 1'b0;
    case (r_state)
      S_PLL_RST:   if (r_count == CNT_W'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_locked_s)                                  w_next = S_STABLE;
        else if (r_count == CNT_W'(LOCK_TIMEOUT - 1))    w_retry_evt = 1'b1;
      end
      S_STABLE: begin
        if (!w_locked_s)                                 w_retry_evt = 1'b1;
        else if (r_count == CNT_W'(STABLE_CYCLES - 1))   w_next = S_RUN;
      end
      S_RUN:       if (!w_locked_s) w_retry_evt = 1'b1;
      S_FAIL:      w_next = S_FAIL;
      default:     w_next = S_PLL_RST;
    endcase
    if (w_retry_evt)
      w_next = w_limit_hit ? S_FAIL : S_PLL_RST;
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    w_pll_rst_nxt    = (w_next == S_PLL_RST) || (w_next == S_FAIL);
    w_core_rst_n_nxt = (w_next == S_RUN);
    w_fail_nxt       = (w_next == S_FAIL);
  end

  assign pll_rst     = r_pll_rst;
  assign core_rst_n  = r_core_rst_n;
  assign seq_state   = r_state;
  assign retry_count = r_retry;
  assign fail        = LIMIT_EN && r_fail;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic               osc_300 = 1'b0;
  logic               rst_n;
  logic               pll_locked;
  logic               pll_rst;
  logic               core_rst_n;
  logic [2:0]         seq_state;
  logic [RETRY_W-1:0] retry_count;
  logic               fail;

  int n_checks = 0;
  int n_errors = 0;

  logic watch = 1'b0;
  logic core_seen_high = 1'b0;

  pll_lock_sequencer #(
    .RST_CYCLES    (8),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (16),
    .MAX_RETRIES   (3)
  ) dut (
    .osc_300     (osc_300),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .core_rst_n  (core_rst_n),
    .seq_state   (seq_state),
    .retry_count (retry_count),
    .fail        (fail)
  );

  always #5 osc_300 = ~osc_300;

  always @(negedge osc_300) begin
    if (!watch)          core_seen_high = 1'b0;
    else if (core_rst_n) core_seen_high = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc_300);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int lim, output int n);
    n = 0;
    while (seq_state != tgt && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_leave(input logic [2:0] st, input int lim, output int n);
    n = 0;
    while (seq_state == st && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (3) tick();
    check("rst_pll_rst", pll_rst, 1);
    check("rst_core", core_rst_n, 0);
    check("rst_state", seq_state, S_PLL_RST);
    check("rst_retry", retry_count, 0);
    check("rst_fail", fail, 0);

    // Lock never arrives: 8-cycle reset pulse, 100-cycle wait, repeat.
    rst_n = 1'b1;
    wait_state(S_WAIT_LOCK, 50, n);
    check("s2_first_rst_len", n, 8);
    for (int a = 1; a <= 3; a++) begin
      wait_leave(S_WAIT_LOCK, 200, n);
      check("s2_timeout_len", n, 100);
`ifdef PLL_RETRY_LIMIT_EN
      if (a == 3) begin
        check("s2_fail_state", seq_state, S_FAIL);
        check("s2_fail_flag", fail, 1);
        check("s2_fail_pll_rst", pll_rst, 1);
      end else begin
        check("s2_retry_state", seq_state, S_PLL_RST);
        check("s2_retry_cnt", retry_count, a);
        check("s2_fail_low", fail, 0);
        wait_leave(S_PLL_RST, 50, n);
        check("s2_rst_len", n, 8);
      end
`else
      check("s2_retry_state", seq_state, S_PLL_RST);
      check("s2_retry_pll_rst", pll_rst, 1);
      check("s2_retry_cnt", retry_count, a);
      check("s2_fail_low", fail, 0);
      if (a < 3) begin
        wait_leave(S_PLL_RST, 50, n);
        check("s2_rst_len", n, 8);
      end
`endif
    end
`ifdef PLL_RETRY_LIMIT_EN
    repeat (150) tick();
    check("s2_fail_sticky", seq_state, S_FAIL);
    check("s2_fail_core", core_rst_n, 0);
`endif

    // Asynchronous reset between clock edges.
    tick();
    rst_n = 1'b0;
    #2;
    check("async_state", seq_state, S_PLL_RST);
    check("async_retry", retry_count, 0);
    check("async_fail", fail, 0);
    check("async_pll_rst", pll_rst, 1);
    tick();
    rst_n = 1'b1;

    // Normal bring-up: lock 20 cycles after pll_rst falls.
    repeat (7) tick();
    check("s1_rst_hold", pll_rst, 1);
    tick();
    check("s1_rst_fall", pll_rst, 0);
    check("s1_wait_state", seq_state, S_WAIT_LOCK);
    repeat (20) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("s1_sync_latency", seq_state, S_WAIT_LOCK);
    tick();
    check("s1_stable", seq_state, S_STABLE);
    repeat (15) tick();
    check("s1_core_held", core_rst_n, 0);
    tick();
    check("s1_run", seq_state, S_RUN);
    check("s1_core_rel", core_rst_n, 1);
    check("s1_retry", retry_count, 0);

    // One-cycle lock drop while running.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("s3_core_still", core_rst_n, 1);
    tick();
    check("s3_core_drop", core_rst_n, 0);
    check("s3_pll_rst", pll_rst, 1);
    check("s3_state", seq_state, S_PLL_RST);
    check("s3_retry", retry_count, 1);
    wait_state(S_RUN, 100, n);
    check("s3_rerun_len", n, 25);

    // Glitch in S_STABLE at count 10.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("s4_retry_a", retry_count, 2);
    wait_state(S_STABLE, 50, n);
    check("s4_to_stable", n, 9);
    watch = 1'b1;
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("s4_still_stable", seq_state, S_STABLE);
    tick();
    check("s4_back_rst", seq_state, S_PLL_RST);
    check("s4_retry_b", retry_count, 3);
    wait_state(S_STABLE, 50, n);
    check("s4_restable", n, 9);
    check("s4_core_never", core_seen_high, 0);
    watch = 1'b0;
    wait_state(S_RUN, 50, n);
    check("s4_full_window", n, 16);

    // Lock becomes visible on the timeout terminal-count cycle.
    pll_locked = 1'b0;
    repeat (3) tick();
    check("s5_drop", seq_state, S_PLL_RST);
    check("s5_retry_a", retry_count, 4);
    wait_state(S_WAIT_LOCK, 50, n);
    check("s5_to_wait", n, 8);
    repeat (97) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("s5_no_early", seq_state, S_WAIT_LOCK);
    tick();
    check("s5_lock_wins", seq_state, S_STABLE);
    check("s5_retry_b", retry_count, 4);

    // Reset mid-S_STABLE, then mid-S_RUN.
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("s6a_pll_rst", pll_rst, 1);
    check("s6a_core", core_rst_n, 0);
    check("s6a_state", seq_state, S_PLL_RST);
    check("s6a_retry", retry_count, 0);
    check("s6a_fail", fail, 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_state(S_RUN, 100, n);
    check("s6a_restart", n, 25);
    check("s6a_core_rel", core_rst_n, 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    check("s6b_core", core_rst_n, 0);
    check("s6b_pll_rst", pll_rst, 1);
    check("s6b_state", seq_state, S_PLL_RST);
    tick();
    rst_n = 1'b1;
    wait_state(S_RUN, 100, n);
    check("s6b_restart", n, 25);
    check("s6b_retry", retry_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
